// File: rtl/elementwise_alu.sv
// Streaming element-wise signed ALU (MUL/ADD/SUB/COPY) between operand BRAMs A/B and a result BRAM.
// Define ELEMWISE_SAT_EN to saturate out-of-range results instead of wrapping them.
module elementwise_alu #(
    parameter int BRAM_WIDTH = 32,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ps_control,
    output logic [31:0]           pl_status,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_a,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_b,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_a,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_b,
    output logic [WORD_BYTES-1:0] bram_we_a,
    output logic [WORD_BYTES-1:0] bram_we_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_result,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_result,
    output logic [WORD_BYTES-1:0] bram_we_result
);

    localparam int          DEPTH   = (2 ** ADDR_WIDTH) / WORD_BYTES;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [BRAM_WIDTH-1:0] SAT_MAX = {1'b0, {(BRAM_WIDTH-1){1'b1}}};
    localparam logic [BRAM_WIDTH-1:0] SAT_MIN = {1'b1, {(BRAM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB, OP_COPY} op_t;

    state_t state, state_next;

    logic                  start;
    logic [31:0]           count_ext;
    logic [CW-1:0]         n_sel;
    logic                  unused_ctrl;

    op_t                   op_q;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         rd_idx;
    logic [ADDR_WIDTH-1:0] rd_addr_now;
    logic                  ovf_q;
    logic                  busy;
    logic                  done;

    logic                  rd_vld;
    logic                  rd_last;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic [BRAM_WIDTH-1:0] pipe_data [PIPE_DEPTH];
    logic [ADDR_WIDTH-1:0] pipe_addr [PIPE_DEPTH];
    logic                  pipe_vld  [PIPE_DEPTH];
    logic                  pipe_last [PIPE_DEPTH];

    assign start       = ps_control[0];
    assign count_ext   = {16'd0, ps_control[31:16]};
    assign unused_ctrl = ^ps_control[15:3];
    assign rd_addr_now = ADDR_WIDTH'(rd_idx) * ADDR_WIDTH'(WORD_BYTES);

    // A count of zero or one beyond the BRAM depth means "the whole BRAM".
    always_comb begin
        if (count_ext == 32'd0 || count_ext > DEPTH_W)
            n_sel = CW'(DEPTH);
        else
            n_sel = count_ext[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (rd_idx == n_q - CW'(1)) state_next = DRAIN;
            DRAIN:   if (pipe_vld[PIPE_DEPTH-1] && pipe_last[PIPE_DEPTH-1]) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == RUN) || (state == DRAIN);
        done        = (state == DONE);
        bram_addr_a = (state == RUN) ? rd_addr_now : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_MUL;
            n_q     <= '0;
            rd_idx  <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (state == IDLE && start) begin
                op_q   <= op_t'(ps_control[2:1]);
                n_q    <= n_sel;
                rd_idx <= '0;
            end else if (state == RUN) begin
                rd_idx <= rd_idx + CW'(1);
            end
            rd_vld  <= (state == RUN);
            rd_last <= (state == RUN) && (rd_idx == n_q - CW'(1));
            rd_addr <= rd_addr_now;
        end
    end

    // Operands arrive one cycle after their address; the op result is formed combinationally here.
    logic signed [2*BRAM_WIDTH-1:0] a_x, b_x, prod;
    logic signed [BRAM_WIDTH:0]     a_e, b_e, sum, diff;
    logic [BRAM_WIDTH-1:0]          res_c;
    logic                           ovf_c;
    logic                           exact_neg;

    assign a_x  = {{BRAM_WIDTH{bram_rddata_a[BRAM_WIDTH-1]}}, bram_rddata_a};
    assign b_x  = {{BRAM_WIDTH{bram_rddata_b[BRAM_WIDTH-1]}}, bram_rddata_b};
    assign prod = a_x * b_x;
    assign a_e  = {bram_rddata_a[BRAM_WIDTH-1], bram_rddata_a};
    assign b_e  = {bram_rddata_b[BRAM_WIDTH-1], bram_rddata_b};
    assign sum  = a_e + b_e;
    assign diff = a_e - b_e;

    always_comb begin
        res_c     = bram_rddata_a;
        ovf_c     = 1'b0;
        exact_neg = 1'b0;
        case (op_q)
            OP_MUL: begin
                res_c     = prod[BRAM_WIDTH-1:0];
                ovf_c     = !(&prod[2*BRAM_WIDTH-1:BRAM_WIDTH-1]) && (|prod[2*BRAM_WIDTH-1:BRAM_WIDTH-1]);
                exact_neg = prod[2*BRAM_WIDTH-1];
            end
            OP_ADD: begin
                res_c     = sum[BRAM_WIDTH-1:0];
                ovf_c     = sum[BRAM_WIDTH] ^ sum[BRAM_WIDTH-1];
                exact_neg = sum[BRAM_WIDTH];
            end
            OP_SUB: begin
                res_c     = diff[BRAM_WIDTH-1:0];
                ovf_c     = diff[BRAM_WIDTH] ^ diff[BRAM_WIDTH-1];
                exact_neg = diff[BRAM_WIDTH];
            end
            default: begin
                res_c     = bram_rddata_a;
                ovf_c     = 1'b0;
                exact_neg = 1'b0;
            end
        endcase
`ifdef ELEMWISE_SAT_EN
        if (ovf_c)
            res_c = exact_neg ? SAT_MIN : SAT_MAX;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (state == IDLE && start)
            ovf_q <= 1'b0;
        else if (rd_vld && ovf_c)
            ovf_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_data[i] <= '0;
                pipe_addr[i] <= '0;
                pipe_vld[i]  <= 1'b0;
                pipe_last[i] <= 1'b0;
            end
        end else begin
            pipe_data[0] <= res_c;
            pipe_addr[0] <= rd_addr;
            pipe_vld[0]  <= rd_vld;
            pipe_last[0] <= rd_last;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    assign bram_addr_b        = bram_addr_a;
    assign bram_wrdata_a      = '0;
    assign bram_wrdata_b      = '0;
    assign bram_we_a          = '0;
    assign bram_we_b          = '0;
    assign bram_we_result     = {WORD_BYTES{pipe_vld[PIPE_DEPTH-1]}};
    assign bram_addr_result   = pipe_vld[PIPE_DEPTH-1] ? pipe_addr[PIPE_DEPTH-1] : '0;
    assign bram_wrdata_result = pipe_vld[PIPE_DEPTH-1] ? pipe_data[PIPE_DEPTH-1] : '0;
    assign pl_status          = {29'd0, ovf_q, busy, done};

endmodule

// File: tb/tb_elementwise_alu.sv
// Scoreboard bench for elementwise_alu: BRAM models, arithmetic reference model, randomized runs.
// Expected saturated vs wrapped values follow ELEMWISE_SAT_EN.
module tb_elementwise_alu;

    localparam int W  = 32;
    localparam int WB = 4;
    localparam int AW = 12;
    localparam int P  = 2;
    localparam int D  = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   ps_control;
    logic [31:0]   pl_status;
    logic [AW-1:0] bram_addr_a, bram_addr_b, bram_addr_result;
    logic [W-1:0]  bram_rddata_a, bram_rddata_b;
    logic [W-1:0]  bram_wrdata_a, bram_wrdata_b, bram_wrdata_result;
    logic [WB-1:0] bram_we_a, bram_we_b, bram_we_result;

    elementwise_alu #(.BRAM_WIDTH(W), .WORD_BYTES(WB), .ADDR_WIDTH(AW), .PIPE_DEPTH(P)) dut (
        .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
        .bram_addr_a(bram_addr_a), .bram_addr_b(bram_addr_b),
        .bram_rddata_a(bram_rddata_a), .bram_rddata_b(bram_rddata_b),
        .bram_wrdata_a(bram_wrdata_a), .bram_wrdata_b(bram_wrdata_b),
        .bram_we_a(bram_we_a), .bram_we_b(bram_we_b),
        .bram_addr_result(bram_addr_result), .bram_wrdata_result(bram_wrdata_result),
        .bram_we_result(bram_we_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    logic [W-1:0] mem_a [D];
    logic [W-1:0] mem_b [D];
    logic [W-1:0] mem_r [D];
    logic [W-1:0] exp_mem [D];
    exp_t         exp_q [$];
    int           compared = 0;
    int           mismatched = 0;
    logic         fill_req = 1'b0;
    logic [W-1:0] fill_val = '0;

    // Operand BRAMs with one-cycle read latency; result BRAM written on all-ones byte enables.
    always @(posedge clk) begin
        bram_rddata_a <= mem_a[bram_addr_a[AW-1:2]];
        bram_rddata_b <= mem_b[bram_addr_b[AW-1:2]];
        if (fill_req) begin
            for (int i = 0; i < D; i++) mem_r[i] <= fill_val;
        end else if (bram_we_result == 4'hF) begin
            mem_r[bram_addr_result[AW-1:2]] <= bram_wrdata_result;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bram_we_result != '0) begin
            checkOutput("write expected by scoreboard", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("write enable", bram_we_result, 4'hF);
                checkOutput("write address", bram_addr_result, e.addr);
                checkOutput("write data", bram_wrdata_result, e.data);
            end
        end
    end

    function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic ovf);
        longint ea, eb, ex;
        ea = longint'($signed(a));
        eb = longint'($signed(b));
        case (op)
            2'd0:    ex = ea * eb;
            2'd1:    ex = ea + eb;
            2'd2:    ex = ea - eb;
            default: ex = ea;
        endcase
        ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        res = ex[W-1:0];
`ifdef ELEMWISE_SAT_EN
        if (ovf) res = (ex < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    endfunction

    function automatic logic [W-1:0] randWord();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'(int'($urandom_range(0, 200)) - 100);
            default: return $urandom();
        endcase
    endfunction

    task automatic pushExpected(input logic [1:0] op, input int n, output logic exp_ovf);
        logic [W-1:0] r;
        logic         o;
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            refModel(op, mem_a[i], mem_b[i], r, o);
            exp_q.push_back('{addr: AW'(i * WB), data: r});
            exp_mem[i] = r;
            exp_ovf |= o;
        end
    endtask

    // One full run: start, then watch timing of first write, busy span, done and overflow.
    task automatic applyStimulus(input logic [1:0] op, input int count, input string tag);
        int   n, done_k, first_we, busy_cnt;
        logic exp_ovf;
        logic [AW-1:0] max_addr;
        n = (count == 0 || count > D) ? D : count;
        pushExpected(op, n, exp_ovf);
        @(negedge clk);
        ps_control = {16'(count), 13'd0, op, 1'b1};
        @(posedge clk);
        done_k = -1; first_we = -1; busy_cnt = 0; max_addr = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bram_addr_a > max_addr) max_addr = bram_addr_a;
            if (first_we < 0 && bram_we_result != '0) first_we = k;
            if (pl_status[1]) busy_cnt++;
            if (pl_status[0]) begin
                done_k = k;
                break;
            end
        end
        checkOutput({tag, " done cycle"}, done_k, n + 1 + P);
        checkOutput({tag, " busy cycles"}, busy_cnt, n + 1 + P);
        checkOutput({tag, " first write cycle"}, first_we, 1 + P);
        checkOutput({tag, " highest read address"}, max_addr, (n - 1) * WB);
        checkOutput({tag, " overflow"}, pl_status[2], exp_ovf);
        checkOutput({tag, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    task automatic finishRun(input int hold);
        int held = 0;
        repeat (hold) begin
            @(negedge clk);
            if (pl_status[0]) held++;
        end
        checkOutput("done held while start high", held, hold);
        ps_control = 32'd0;
        @(negedge clk);
        checkOutput("done falls after start", pl_status[0], 0);
    endtask

    task automatic prefillResult(input logic [W-1:0] val);
        @(negedge clk);
        fill_val = val;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        for (int i = 0; i < D; i++) exp_mem[i] = val;
    endtask

    task automatic checkMem(input string tag);
        int bad = 0;
        for (int i = 0; i < D; i++) if (mem_r[i] !== exp_mem[i]) bad++;
        checkOutput({tag, " result words wrong"}, bad, 0);
    endtask

    task automatic randomOperands(input int n);
        for (int i = 0; i < n; i++) begin
            mem_a[i] = randWord();
            mem_b[i] = randWord();
        end
    endtask

    initial begin
        logic [1:0] op;
        logic       eo;
        int         found;

        reset = 1'b1;
        ps_control = 32'd0;
        for (int i = 0; i < D; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset pl_status", pl_status, 0);
        checkOutput("reset addr_a", bram_addr_a, 0);
        checkOutput("reset addr_b", bram_addr_b, 0);
        checkOutput("reset we_result", bram_we_result, 0);
        checkOutput("reset addr_result", bram_addr_result, 0);
        checkOutput("reset wrdata_result", bram_wrdata_result, 0);
        checkOutput("reset operand port writes", {bram_we_a, bram_we_b, bram_wrdata_a, bram_wrdata_b}, 0);
        reset = 1'b0;
        prefillResult(32'd0);

        $display("[TB] MUL over full BRAM");
        for (int i = 0; i < D; i++) begin
            mem_a[i] = 32'd2;
            mem_b[i] = 32'd3;
        end
        applyStimulus(2'd0, 0, "mul_full");
        finishRun(0);
        checkMem("mul_full");
        checkOutput("mul_full last word", mem_r[D-1], 32'd6);

        $display("[TB] SUB of five words into prefilled BRAM");
        prefillResult(32'hDEAD_BEEF);
        for (int i = 0; i < D; i++) begin
            mem_a[i] = 32'd10;
            mem_b[i] = 32'hFFFF_FFFC;
        end
        applyStimulus(2'd2, 5, "sub5");
        finishRun(1);
        checkMem("sub5");
        checkOutput("sub5 word 4", mem_r[4], 32'd14);
        checkOutput("sub5 word 5 untouched", mem_r[5], 32'hDEAD_BEEF);

        $display("[TB] ADD overflow");
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'h7FFF_FFFF;
            mem_b[i] = 32'd1;
        end
        applyStimulus(2'd1, 4, "add_ovf");
        finishRun(0);
`ifdef ELEMWISE_SAT_EN
        checkOutput("add_ovf word 0", mem_r[0], 32'h7FFF_FFFF);
`else
        checkOutput("add_ovf word 0", mem_r[0], 32'h8000_0000);
`endif

        $display("[TB] MUL overflow then COPY clears flag");
        for (int i = 0; i < 3; i++) begin
            mem_a[i] = 32'h0001_0000;
            mem_b[i] = 32'h0001_0000;
        end
        applyStimulus(2'd0, 3, "mul_ovf");
        checkOutput("mul_ovf flag", pl_status[2], 1);
        finishRun(0);
`ifdef ELEMWISE_SAT_EN
        checkOutput("mul_ovf word 0", mem_r[0], 32'h7FFF_FFFF);
`else
        checkOutput("mul_ovf word 0", mem_r[0], 32'h0000_0000);
`endif
        randomOperands(3);
        applyStimulus(2'd3, 3, "copy");
        checkOutput("copy clears overflow", pl_status[2], 0);
        finishRun(0);

        $display("[TB] randomized short runs");
        for (int r = 0; r < 8; r++) begin
            randomOperands(64);
            op = 2'($urandom_range(0, 3));
            applyStimulus(op, $urandom_range(1, 60), "random");
            finishRun($urandom_range(0, 3));
        end

        $display("[TB] handshake hold and clamped count");
        randomOperands(8);
        applyStimulus(2'($urandom_range(0, 3)), 8, "hold");
        finishRun(10);
        randomOperands(D);
        applyStimulus(2'($urandom_range(0, 3)), 2000, "clamp");
        finishRun(0);
        checkMem("clamp");

        $display("[TB] reset in the middle of a run");
        randomOperands(D);
        op = 2'($urandom_range(0, 3));
        pushExpected(op, D, eo);
        @(negedge clk);
        ps_control = {16'd0, 13'd0, op, 1'b1};
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bram_we_result != '0 && bram_addr_result == AW'(100 * WB)) begin
                found = 1;
                break;
            end
        end
        checkOutput("abort reached element 100", found, 1);
        reset = 1'b1;
        ps_control = 32'd0;
        @(negedge clk);
        checkOutput("abort pl_status", pl_status, 0);
        checkOutput("abort we_result", bram_we_result, 0);
        checkOutput("abort addr_a", bram_addr_a, 0);
        checkOutput("abort addr_result", bram_addr_result, 0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort no writes after reset", bram_we_result, 0);
        randomOperands(D);
        applyStimulus(2'($urandom_range(0, 3)), 0, "rerun");
        finishRun(0);
        checkMem("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/elementwise_alu.md
# elementwise_alu

Parametrised successor to the hadamard block: streams two operand vectors out of BRAMs A and B, applies one selectable signed-integer operation per element (MUL, ADD, SUB, COPY), and writes results to the result BRAM. Throughput is one element per cycle. Element count is programmable per run. It sits on the PL side behind the same PS/PL BRAM muxes and the same ps_control/pl_status register pair as the hadamard block.

## Interface
Parameters:
- BRAM_WIDTH, 32, element width in bits (signed two's complement)
- WORD_BYTES, 4, bytes per element; BRAM byte-address stride
- ADDR_WIDTH, 12, BRAM byte-address width; depth D = 2**ADDR_WIDTH / WORD_BYTES
- PIPE_DEPTH, 2, register stages after the combinational operation (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ps_control  in  32  [0] start, [2:1] op (00 MUL, 01 ADD, 10 SUB, 11 COPY A), [31:16] element count
- pl_status  out  32  [0] done, [1] busy, [2] overflow (sticky), [31:3] zero
- bram_addr_a / bram_addr_b  out  ADDR_WIDTH  operand read byte address
- bram_rddata_a / bram_rddata_b  in  BRAM_WIDTH  operand data, 1-cycle read latency
- bram_wrdata_a / bram_wrdata_b  out  BRAM_WIDTH  tied 0
- bram_we_a / bram_we_b  out  WORD_BYTES  tied 0
- bram_addr_result  out  ADDR_WIDTH  result write byte address
- bram_wrdata_result  out  BRAM_WIDTH  result data
- bram_we_result  out  WORD_BYTES  all-ones on a write, else 0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: busy=0, done=0. When start=1 at a clk edge, the block latches op and count, clears overflow, and moves to RUN.
- Count rule: N = count. If count=0, N = D. If count > D, N is clamped to D.
- RUN: issues read address i*WORD_BYTES for i = 0..N-1, one per cycle, then moves to DRAIN.
- DRAIN: waits until the last result has been written, then moves to DONE.
- DONE: done=1, busy=0. The block stays in DONE while start=1. When start=0 it returns to IDLE on the next edge, so done falls one cycle after start falls. This is a 4-phase handshake.
- ps_control is sampled only in IDLE. Changes to start, op or count during RUN/DRAIN are ignored.
- Arithmetic:
  - MUL takes the full 2·BRAM_WIDTH signed product; the result is the low BRAM_WIDTH bits.
  - ADD and SUB use BRAM_WIDTH signed wrap.
  - COPY writes A unchanged and never overflows.
- Overflow: sets when the exact result falls outside the signed BRAM_WIDTH range. It stays set until the next start.
- Reset at any point, including mid-run: on the next edge the state is IDLE and pl_status=0. All bram_addr_*=0 and bram_we_*=0. Writes stop immediately. Already-written results are left in place and the pipeline is flushed.
- Addresses never exceed (D-1)*WORD_BYTES. There is no wrap-around.

## Timing
- Cycle n is the first RUN cycle, which is the cycle after the edge that sampled start.
- Read address for element i is driven in cycle n+i.
- bram_we_result is asserted with address i*WORD_BYTES in cycle n+i+1+PIPE_DEPTH.
- Writes are back-to-back with no bubbles.
- done rises in cycle n+N+1+PIPE_DEPTH.
- busy is high from cycle n through the last write cycle.
- Reset value of every output: 0.

## Configuration
- ELEMWISE_SAT_EN defined: an out-of-range result saturates to the signed max (0x7FFFFFFF for width 32) or signed min (0x80000000).
- ELEMWISE_SAT_EN undefined: results wrap as described under Operation.
- The overflow flag behaves identically in both builds.

## Test plan
- MUL, count=0, A=2, B=3 in all 1024 words -> all 1024 results = 6. done rises at n+1027; overflow=0.
- SUB, count=5, A=10, B=-4, result BRAM prefilled 0xDEADBEEF -> words 0..4 = 14; word 5 onward still 0xDEADBEEF.
- ADD, A=0x7FFFFFFF, B=1 -> result 0x7FFFFFFF with ELEMWISE_SAT_EN, 0x80000000 without; overflow=1 in both builds.
- MUL, A=0x00010000, B=0x00010000 -> saturated 0x7FFFFFFF or wrapped 0x00000000; overflow=1. A following COPY run clears overflow.
- Handshake: hold start 10 cycles after done -> done stays 1. Drop start -> done=0 one cycle later. Restart with count=2000 -> clamps to 1024; highest address seen is 0xFFC.
- Assert reset at element 100 of a 1024-element run -> next cycle pl_status=0, we_result=0. A rerun then produces correct results in all 1024 words.
